bit_serializer: RTL and testbench

Upstream feeder for the serial sequence-detector stage. It accepts a parallel word over a valid/ready handshake and emits it one bit per clock on `x`, which drives the detector's serial input. It supports back-to-back words with no idle gap. It also supports a stall input, and `x_valid` qualifies every emitted bit.

---
 rtl/serial_pkg.sv | 13 +
 rtl/bit_serializer.sv | 71 +++++++
 tb/tb_bit_serializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial feeder and the sequence-detector stage.
// The idle-line value is shared so the detector bench sees the same quiet level.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int   SERIAL_WIDTH    = 8;
  localparam logic SERIAL_IDLE_BIT = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: takes a word over valid/ready and emits one bit
// per clock on x, with stall support and gapless back-to-back words.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH     = SERIAL_WIDTH,
  parameter bit   LSB_FIRST = 1'b0,
  parameter logic IDLE_BIT  = SERIAL_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             stall,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           st_q, st_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;

  always_comb begin
    busy      = (st_q == SHIFT);
    x_valid   = busy && !stall;
    x         = busy ? (LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1]) : IDLE_BIT;
    last      = x_valid && (cnt_q == CNT_LAST);
    din_ready = !busy || last;
    accept    = din_valid && din_ready;
  end

  // An accept on the last bit wins over returning to IDLE, giving no idle gap.
  always_comb begin
    st_d  = st_q;
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (accept) begin
      sr_d  = din;
      cnt_d = '0;
      st_d  = SHIFT;
    end else if (x_valid) begin
      sr_d = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
      if (last) begin
        st_d  = IDLE;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= IDLE;
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer: default MSB-first 8-bit
// instance plus a 4-bit LSB-first instance.
module tb_bit_serializer;

  logic       clk;
  logic       reset;

  logic [7:0] din;
  logic       din_valid, stall;
  logic       din_ready, x, x_valid, last, busy;

  logic [3:0] din4;
  logic       din_valid4, stall4;
  logic       din_ready4, x4, x_valid4, last4, busy4;

  int errors = 0;
  int checks = 0;

  bit_serializer dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .stall(stall), .x(x), .x_valid(x_valid),
    .last(last), .busy(busy)
  );

  bit_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut4 (
    .clk(clk), .reset(reset), .din(din4), .din_valid(din_valid4),
    .din_ready(din_ready4), .stall(stall4), .x(x4), .x_valid(x_valid4),
    .last(last4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] word);
    @(posedge clk); #1;
    din       = word;
    din_valid = 1'b1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".busy"},      busy,      1'b0);
    checkOutput({tag, ".x"},         x,         1'b0);
    checkOutput({tag, ".x_valid"},   x_valid,   1'b0);
    checkOutput({tag, ".last"},      last,      1'b0);
    checkOutput({tag, ".din_ready"}, din_ready, 1'b1);
  endtask

  // Checks one non-stalled bit cycle at the negedge, then advances past the next posedge.
  task automatic checkBit(input string tag, input logic exp_x, input logic exp_last);
    @(negedge clk);
    checkOutput({tag, ".x"},         x,         exp_x);
    checkOutput({tag, ".x_valid"},   x_valid,   1'b1);
    checkOutput({tag, ".last"},      last,      exp_last);
    checkOutput({tag, ".din_ready"}, din_ready, exp_last);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] pair;

    reset = 1'b0; din = '0; din_valid = 1'b0; stall = 1'b0;
    din4 = '0; din_valid4 = 1'b0; stall4 = 1'b0;

    // Test 1: reset state before any clock edge
    #2;
    checkIdle("reset0");
    checkOutput("reset0.busy4", busy4, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Test 2: single word A5, MSB first
    w = 8'hA5;
    applyStimulus(w);
    @(negedge clk);
    checkOutput("t2.ready_idle", din_ready, 1'b1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) checkBit("t2", w[7-i], i == 7);
    @(negedge clk);
    checkIdle("t2.after");

    // Test 3: back-to-back A5 then 3C, second accepted on the last cycle
    pair = 16'hA53C;
    applyStimulus(8'hA5);
    @(posedge clk); #1;
    din = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checkOutput("t3.x",       x,       pair[15-i]);
      checkOutput("t3.x_valid", x_valid, 1'b1);
      checkOutput("t3.last",    last,    (i == 7) || (i == 15));
      @(posedge clk); #1;
      if (i == 7) din_valid = 1'b0;
    end
    @(negedge clk);
    checkIdle("t3.after");

    // Test 4: F0 with a 3-cycle stall while bit index 4 is presented
    w = 8'hF0;
    applyStimulus(w);
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) checkBit("t4.pre", w[7-i], 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t4.stall.x",       x,         1'b0);
      checkOutput("t4.stall.x_valid", x_valid,   1'b0);
      checkOutput("t4.stall.last",    last,      1'b0);
      checkOutput("t4.stall.ready",   din_ready, 1'b0);
      checkOutput("t4.stall.busy",    busy,      1'b1);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    for (int i = 4; i < 8; i++) checkBit("t4.post", w[7-i], i == 7);
    @(negedge clk);
    checkIdle("t4.after");

    // Test 5: reset mid-word, then a clean 81
    w = 8'hA5;
    applyStimulus(w);
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) checkBit("t5.pre", w[7-i], 1'b0);
    #1 reset = 1'b0;
    #1;
    checkIdle("t5.reset");
    @(posedge clk); #1;
    reset = 1'b1;
    w = 8'h81;
    applyStimulus(w);
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) checkBit("t5.post", w[7-i], i == 7);
    @(negedge clk);
    checkIdle("t5.after");

    // Test 6: 4-bit LSB-first instance, accept while stall is high in IDLE
    @(posedge clk); #1;
    din4 = 4'b0001; din_valid4 = 1'b1; stall4 = 1'b1;
    @(negedge clk);
    checkOutput("t6.ready_idle_stall", din_ready4, 1'b1);
    @(posedge clk); #1;
    din_valid4 = 1'b0; stall4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t6.x",       x4,       (i == 0));
      checkOutput("t6.x_valid", x_valid4, 1'b1);
      checkOutput("t6.last",    last4,    (i == 3));
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("t6.after.busy", busy4, 1'b0);
    checkOutput("t6.after.x",    x4,    1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
